gmii_tx_framer: RTL
===================

# gmii_tx_framer

Byte-wide GMII transmit framer sitting directly upstream of the RGMII ODDR output stage. Accepts raw frame payload bytes from the MAC-side streaming interface over a valid/ready handshake. Emits a complete Ethernet frame on `tx_dat`/`tx_en`: preamble, SFD, payload, optional minimum-length pad and CRC-32 FCS. Enforces the inter-frame gap between frames. All logic runs in the `sclk` (125 MHz) domain feeding the ODDR stage.

## Interface
- `IFG_CYCLES`, 12: minimum idle `sclk` cycles (tx_en low) between frames
- `PREAMBLE_LEN`, 7: number of 0x55 bytes before SFD
- `MIN_PAYLOAD`, 60: minimum payload+pad length in bytes, FCS excluded; only used with padding enabled
- `sclk` in 1: transmit clock, all logic rising-edge
- `rst` in 1: reset, asynchronous and active-high
- `s_data` in 8: payload byte
- `s_valid` in 1: `s_data` valid
- `s_last` in 1: qualifies the final payload byte of the frame
- `s_ready` out 1: framer accepts a byte this cycle
- `tx_dat` out 8: GMII data to the ODDR stage, registered
- `tx_en` out 1: GMII enable to the ODDR stage, registered
- `tx_underrun` out 1: one-cycle pulse when upstream starves mid-payload
- `busy` out 1: high in any state other than IDLE

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DRAIN.
- IDLE:
  - `s_ready`=0.
  - If `s_valid`=1, go to PRE. The byte is not consumed.
- PRE: emit 0x55 for PREAMBLE_LEN cycles, then go to SFD.
- SFD: emit 0xD5 for 1 cycle, then go to DATA.
- DATA:
  - `s_ready`=1 combinationally (`s_ready` = state==DATA or state==DRAIN).
  - Each handshake (`s_valid`&`s_ready`) emits `s_data` and feeds the CRC.
  - On `s_last`: if byte count < MIN_PAYLOAD (pad enabled), go to PAD; else go to FCS.
- PAD: emit 0x00, fed to the CRC, until byte count = MIN_PAYLOAD, then go to FCS.
- FCS:
  - Emit 4 bytes of ~CRC, least-significant byte first, then go to IFG.
  - CRC-32 parameters: poly 0x04C11DB7, reflected, init 0xFFFFFFFF.
- IFG: `tx_en`=0 for IFG_CYCLES cycles, then go to IDLE.
- Underrun (DATA, `s_valid`=0):
  - Next edge drives `tx_en`=0 (frame truncated, no FCS) and pulses `tx_underrun` for 1 cycle.
  - Go to DRAIN.
- DRAIN: `s_ready`=1, bytes discarded until `s_last` is accepted, then go to IFG.
- Byte counter: 7-bit, saturating at MIN_PAYLOAD. It only gates padding; payload length is otherwise unlimited.
- `s_last` without `s_valid` is ignored.

## Timing
- Reset values: `tx_dat`=0x00, `tx_en`=0, `s_ready`=0, `tx_underrun`=0, `busy`=0, state=IDLE, CRC=0xFFFFFFFF, counters=0.
- Reset mid-frame clears outputs immediately (asynchronous). No FCS is sent.
- First 0x55 appears on `tx_dat` 2 cycles after the first cycle `s_valid`=1 is sampled in IDLE.
- `tx_en` stays continuously high from the first preamble byte through the last FCS byte.
- A payload byte accepted in cycle n appears on `tx_dat` in cycle n+1.
- The first FCS byte immediately follows the last payload or pad byte, with no bubble.
- After the last FCS byte, `tx_en`=0 for at least IFG_CYCLES cycles before the next 0x55.
- While not transmitting, `tx_dat` holds 0x00.

## Configuration
- `GMII_TX_PAD_EN` defined:
  - Payloads shorter than MIN_PAYLOAD are zero-padded.
  - The padded bytes are covered by the FCS.
- `GMII_TX_PAD_EN` undefined:
  - PAD state and saturating counter are removed.
  - `s_last` always goes directly to FCS. The upstream is responsible for minimum length.

## Structure
- Shared package `gmii_pkg`:
  - Constants: preamble byte 0x55, SFD 0xD5, CRC init 0xFFFFFFFF, poly 0x04C11DB7.
  - State enum type.
- Sub-module `crc32_d8`:
  - Combinational next-CRC for one byte, reflected Ethernet CRC-32.
  - Instantiated once; the CRC register is held in `gmii_tx_framer`.

## Test plan
- Pad disabled, payload ASCII "123456789":
  - Expected `tx_dat`: 7×0x55, 0xD5, 0x31..0x39, then FCS 0x26, 0x39, 0xF4, 0xCB.
  - `tx_en` high for exactly 21 cycles.
- Pad enabled, 1-byte payload 0xAB:
  - Expected: 0xAB followed by 59×0x00 then 4 FCS bytes.
  - `tx_en` high for 72 cycles; FCS matches the reference model.
- Back-to-back frames with `s_valid` held high:
  - Gap between the last FCS byte and the next 0x55 is exactly 12 `tx_en`-low cycles.
  - `s_ready`=0 throughout IFG.
- Underrun: drop `s_valid` for 1 cycle after 10 payload bytes.
  - `tx_en` falls on the next cycle with one `tx_underrun` pulse.
  - Remaining bytes through `s_last` are discarded; 12 IFG cycles follow.
- Assert `rst` during FCS byte 2:
  - `tx_en`=0 and `tx_dat`=0x00 immediately.
  - After release, a new frame starts cleanly with the CRC reinitialised (its FCS is correct).
- `s_valid` toggling every other cycle before SFD:
  - No bytes are consumed before DATA.
  - The first accepted byte is the one presented in the first DATA cycle.

Source files
------------

// File: rtl/gmii_pkg.sv
// Shared constants and state type for the GMII transmit framer.
// Used by gmii_tx_framer and crc32_d8.
package gmii_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG,
      ST_DRAIN
   } tx_state_t;

   // Bit-reverse a 32-bit word; turns the normal poly into its LSB-first form.
   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Pure next-state logic; the CRC register lives in the framer.
module crc32_d8
   import gmii_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   localparam logic [31:0] POLY_R = reflect32(CRC_POLY);

   logic [31:0] crc_v;

   always_comb begin
      crc_v = crc_in ^ {24'd0, data};
      for (int i = 0; i < 8; i++) begin
         crc_v = crc_v[0] ? ((crc_v >> 1) ^ POLY_R) : (crc_v >> 1);
      end
      crc_out = crc_v;
   end

endmodule

// File: rtl/gmii_tx_framer.sv
// Byte-wide GMII transmit framer: preamble, SFD, payload, optional pad, FCS, IFG.
// Define GMII_TX_PAD_EN to zero-pad payloads shorter than MIN_PAYLOAD.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for s_valid; nothing consumed
// PRE      | emitting PREAMBLE_LEN preamble bytes
// SFD      | emitting the start-of-frame delimiter
// DATA     | passing accepted payload bytes through the CRC
// PAD      | emitting zero bytes up to MIN_PAYLOAD
// FCS      | emitting ~CRC, least-significant byte first
// IFG      | tx_en low; together with IDLE gives IFG_CYCLES low cycles
// DRAIN    | after underrun, discarding bytes through s_last
module gmii_tx_framer
   import gmii_pkg::*;
#(
   parameter int IFG_CYCLES   = 12,
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_PAYLOAD  = 60
) (
   input  logic       sclk,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] tx_dat,
   output logic       tx_en,
   output logic       tx_underrun,
   output logic       busy
);

   if (MIN_PAYLOAD < 1 || MIN_PAYLOAD > 127 || IFG_CYCLES < 2 || IFG_CYCLES > 257 ||
       PREAMBLE_LEN < 1 || PREAMBLE_LEN > 256) begin : g_param_range
      $error("gmii_tx_framer parameter out of range for counter widths");
   end

   tx_state_t   state;
   logic [31:0] crc_q;
   logic [31:0] crc_next;
   logic [7:0]  crc_byte;
   logic [7:0]  timer;

`ifdef GMII_TX_PAD_EN
   localparam logic [6:0] MIN_CNT = 7'(MIN_PAYLOAD);
   logic [6:0] byte_cnt;
   assign crc_byte = (state == ST_PAD) ? 8'h00 : s_data;
`else
   assign crc_byte = s_data;
`endif

   assign s_ready = (state == ST_DATA) || (state == ST_DRAIN);
   assign busy    = (state != ST_IDLE);

   crc32_d8 u_crc (
      .crc_in  (crc_q),
      .data    (crc_byte),
      .crc_out (crc_next)
   );

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         crc_q       <= CRC_INIT;
         timer       <= '0;
         tx_dat      <= 8'h00;
         tx_en       <= 1'b0;
         tx_underrun <= 1'b0;
`ifdef GMII_TX_PAD_EN
         byte_cnt    <= '0;
`endif
      end else begin
         tx_underrun <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               tx_dat <= 8'h00;
               tx_en  <= 1'b0;
               crc_q  <= CRC_INIT;
`ifdef GMII_TX_PAD_EN
               byte_cnt <= '0;
`endif
               if (s_valid) begin
                  state <= ST_PRE;
                  timer <= 8'(PREAMBLE_LEN - 1);
               end
            end
            ST_PRE: begin
               tx_dat <= PREAMBLE_BYTE;
               tx_en  <= 1'b1;
               if (timer == 8'd0) state <= ST_SFD;
               else               timer <= timer - 8'd1;
            end
            ST_SFD: begin
               tx_dat <= SFD_BYTE;
               tx_en  <= 1'b1;
               state  <= ST_DATA;
            end
            ST_DATA: begin
               if (s_valid) begin
                  tx_dat <= s_data;
                  tx_en  <= 1'b1;
                  crc_q  <= crc_next;
`ifdef GMII_TX_PAD_EN
                  if (byte_cnt != MIN_CNT) byte_cnt <= byte_cnt + 7'd1;
                  if (s_last) begin
                     if (byte_cnt < MIN_CNT - 7'd1) begin
                        state <= ST_PAD;
                     end else begin
                        state <= ST_FCS;
                        timer <= 8'd3;
                     end
                  end
`else
                  if (s_last) begin
                     state <= ST_FCS;
                     timer <= 8'd3;
                  end
`endif
               end else begin
                  // Starved mid-payload: truncate the frame without an FCS.
                  tx_dat      <= 8'h00;
                  tx_en       <= 1'b0;
                  tx_underrun <= 1'b1;
                  state       <= ST_DRAIN;
               end
            end
`ifdef GMII_TX_PAD_EN
            ST_PAD: begin
               tx_dat   <= 8'h00;
               tx_en    <= 1'b1;
               crc_q    <= crc_next;
               byte_cnt <= byte_cnt + 7'd1;
               if (byte_cnt == MIN_CNT - 7'd1) begin
                  state <= ST_FCS;
                  timer <= 8'd3;
               end
            end
`endif
            ST_FCS: begin
               tx_dat <= ~crc_q[7:0];
               tx_en  <= 1'b1;
               crc_q  <= {8'h00, crc_q[31:8]};
               if (timer == 8'd0) begin
                  state <= ST_IFG;
                  timer <= 8'(IFG_CYCLES - 2);
               end else begin
                  timer <= timer - 8'd1;
               end
            end
            ST_IFG: begin
               // One cycle short: the IDLE cycle completes the gap.
               tx_dat <= 8'h00;
               tx_en  <= 1'b0;
               if (timer == 8'd0) state <= ST_IDLE;
               else               timer <= timer - 8'd1;
            end
            ST_DRAIN: begin
               tx_dat <= 8'h00;
               tx_en  <= 1'b0;
               if (s_valid && s_last) begin
                  state <= ST_IFG;
                  timer <= 8'(IFG_CYCLES - 2);
               end
            end
            default: begin
               tx_dat <= 8'h00;
               tx_en  <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
